// File: rtl/stack_port_sched_if.sv
// Requester-side bus of the stack port scheduler.
// Handshake: a request transfers in the cycle where req_valid[i] && req_ready[i].
// The requester holds valid/we/addr/wdata stable until that cycle.
// req_ready is combinational and never depends on itself.
// rsp_valid/rsp_rdata carry read data exactly one cycle after the grant.
interface stack_port_sched_if #(
    parameter int NREQ  = 8,
    parameter int ADDRW = 6,
    parameter int DATAW = 64
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*DATAW-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ*DATAW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/stack_port_sched.sv
// Round-robin scheduler sharing a 4R/4W stack among NREQ requesters.
// Grants up to 4 writes and 4 reads per cycle.
// Duplicate write addresses are deferred, and reads that hit a granted write are deferred.
// Read data is routed back one cycle after the grant.
module stack_port_sched #(
    parameter int NREQ  = 8,
    parameter int ADDRW = 6,
    parameter int DATAW = 64,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    stack_port_sched_if.slave    bus,
    output logic [4*ADDRW-1:0]   st_read_add,
    input  logic [4*DATAW-1:0]   st_data_out,
    output logic [4*ADDRW-1:0]   st_wrt_add,
    output logic [3:0]           st_wrt_en,
    output logic [4*DATAW-1:0]   st_data_in,
    output logic [31:0]          stall_cnt,
    output logic [IDXW-1:0]      dbg_wr_ptr,
    output logic [IDXW-1:0]      dbg_rd_ptr
);

    // Requester index 'k' steps after 'base', wrapped into 0..NREQ-1.
    function automatic logic [IDXW-1:0] scan_idx(input logic [IDXW-1:0] base, input int k);
        logic [IDXW:0] s;
        s = {1'b0, base} + (IDXW+1)'(k);
        if (s >= (IDXW+1)'(NREQ)) s = s - (IDXW+1)'(NREQ);
        return s[IDXW-1:0];
    endfunction

    // Successor of a requester index, wrapped.
    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        logic [IDXW:0] n;
        n = {1'b0, i} + (IDXW+1)'(1);
        if (n >= (IDXW+1)'(NREQ)) n = '0;
        return n[IDXW-1:0];
    endfunction

    logic [ADDRW-1:0] addr_a  [NREQ];
    logic [DATAW-1:0] wdata_a [NREQ];

    logic [NREQ-1:0]  ready_c;
    logic [3:0]       wen_c;
    logic [ADDRW-1:0] wadd_c [4];
    logic [DATAW-1:0] wdat_c [4];
    logic [3:0]       rvld_c;
    logic [ADDRW-1:0] radd_c [4];
    logic [IDXW-1:0]  ridx_c [4];

    logic [IDXW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDXW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]       rmap_vld_q, rmap_vld_d;
    logic [IDXW-1:0]  rmap_idx_q [4];
    logic [IDXW-1:0]  rmap_idx_d [4];
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic [NREQ-1:0]  rsp_valid_c;
    logic [DATAW-1:0] rsp_data_c [NREQ];

    // Unpack the requester address and data buses into per-requester arrays.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = bus.req_addr[i*ADDRW +: ADDRW];
            wdata_a[i] = bus.req_wdata[i*DATAW +: DATAW];
        end
    end

    // Grant writes and then reads, each scanning round-robin from its own pointer.
    always_comb begin
        logic [IDXW-1:0] idx;
        logic            hit;
        logic [2:0]      wcnt;
        logic [2:0]      rcnt;
        idx      = '0;
        hit      = 1'b0;
        wcnt     = '0;
        rcnt     = '0;
        ready_c  = '0;
        wen_c    = '0;
        rvld_c   = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int p = 0; p < 4; p++) begin
            wadd_c[p] = '0;
            wdat_c[p] = '0;
            radd_c[p] = '0;
            ridx_c[p] = '0;
        end
        // Writes: a second write to an address already granted this cycle waits, using no port.
        for (int k = 0; k < NREQ; k++) begin
            idx = scan_idx(wr_ptr_q, k);
            if (bus.req_valid[idx] && bus.req_we[idx] && (wcnt < 3'd4)) begin
                hit = 1'b0;
                for (int p = 0; p < 4; p++)
                    if (wen_c[p] && (wadd_c[p] == addr_a[idx])) hit = 1'b1;
                if (!hit) begin
                    wen_c[wcnt[1:0]]  = 1'b1;
                    wadd_c[wcnt[1:0]] = addr_a[idx];
                    wdat_c[wcnt[1:0]] = wdata_a[idx];
                    ready_c[idx]      = 1'b1;
                    wr_ptr_d          = next_idx(idx);
                    wcnt              = wcnt + 3'd1;
                end
            end
        end
        // Reads: deferred when a granted write targets the same address, so they see the new value.
        for (int k = 0; k < NREQ; k++) begin
            idx = scan_idx(rd_ptr_q, k);
            if (bus.req_valid[idx] && !bus.req_we[idx] && (rcnt < 3'd4)) begin
                hit = 1'b0;
                for (int p = 0; p < 4; p++)
                    if (wen_c[p] && (wadd_c[p] == addr_a[idx])) hit = 1'b1;
                if (!hit) begin
                    rvld_c[rcnt[1:0]] = 1'b1;
                    radd_c[rcnt[1:0]] = addr_a[idx];
                    ridx_c[rcnt[1:0]] = idx;
                    ready_c[idx]      = 1'b1;
                    rd_ptr_d          = next_idx(idx);
                    rcnt              = rcnt + 3'd1;
                end
            end
        end
    end

    // Drive the stack ports from the grants. Writes are blocked while reset is held.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            st_read_add[p*ADDRW +: ADDRW] = radd_c[p];
            st_wrt_add[p*ADDRW +: ADDRW]  = wadd_c[p];
            st_data_in[p*DATAW +: DATAW]  = wdat_c[p];
        end
        st_wrt_en = reset ? wen_c : 4'b0000;
    end

    // Next-state values for the read grant map and the saturating stall counter.
    always_comb begin
        rmap_vld_d  = rvld_c;
        for (int p = 0; p < 4; p++) rmap_idx_d[p] = ridx_c[p];
        stall_cnt_d = stall_cnt_q;
        if (((bus.req_valid & ~ready_c) != '0) && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Register pointers, the read grant map and the stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rmap_vld_q  <= '0;
            for (int p = 0; p < 4; p++) rmap_idx_q[p] <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rmap_vld_q  <= rmap_vld_d;
            for (int p = 0; p < 4; p++) rmap_idx_q[p] <= rmap_idx_d[p];
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Route each stack read port's data back to the requester granted on it last cycle.
    always_comb begin
        rsp_valid_c = '0;
        for (int i = 0; i < NREQ; i++) rsp_data_c[i] = '0;
        for (int p = 0; p < 4; p++) begin
            if (rmap_vld_q[p]) begin
                rsp_valid_c[rmap_idx_q[p]] = 1'b1;
                rsp_data_c[rmap_idx_q[p]]  = st_data_out[p*DATAW +: DATAW];
            end
        end
    end

    // Pack the outputs.
    always_comb begin
        bus.req_ready = ready_c;
        bus.rsp_valid = rsp_valid_c;
        for (int i = 0; i < NREQ; i++) bus.rsp_rdata[i*DATAW +: DATAW] = rsp_data_c[i];
        stall_cnt  = stall_cnt_q;
        dbg_wr_ptr = wr_ptr_q;
        dbg_rd_ptr = rd_ptr_q;
    end

endmodule

// File: tb/tb_stack_port_sched.sv
// Bench for stack_port_sched: directed scenarios plus randomized traffic against a reference model.
module tb_stack_port_sched;
    localparam int NREQ  = 8;
    localparam int ADDRW = 6;
    localparam int DATAW = 64;
    localparam int IDXW  = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stack_port_sched_if #(.NREQ(NREQ), .ADDRW(ADDRW), .DATAW(DATAW)) bus ();

    logic [4*ADDRW-1:0] st_read_add;
    logic [4*DATAW-1:0] st_data_out;
    logic [4*ADDRW-1:0] st_wrt_add;
    logic [3:0]         st_wrt_en;
    logic [4*DATAW-1:0] st_data_in;
    logic [31:0]        stall_cnt;
    logic [IDXW-1:0]    dbg_wr_ptr;
    logic [IDXW-1:0]    dbg_rd_ptr;

    stack_port_sched #(.NREQ(NREQ), .ADDRW(ADDRW), .DATAW(DATAW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .st_read_add (st_read_add),
        .st_data_out (st_data_out),
        .st_wrt_add  (st_wrt_add),
        .st_wrt_en   (st_wrt_en),
        .st_data_in  (st_data_in),
        .stall_cnt   (stall_cnt),
        .dbg_wr_ptr  (dbg_wr_ptr),
        .dbg_rd_ptr  (dbg_rd_ptr)
    );

    // Stack memory: registered reads, writes on the clock edge.
    logic [DATAW-1:0] stk_mem [64];
    always @(posedge clk) begin
        for (int p = 0; p < 4; p++) begin
            st_data_out[p*DATAW +: DATAW] <= stk_mem[st_read_add[p*ADDRW +: ADDRW]];
            if (st_wrt_en[p]) stk_mem[st_wrt_add[p*ADDRW +: ADDRW]] <= st_data_in[p*DATAW +: DATAW];
        end
    end

    // ---------------- requester drive ----------------
    logic [NREQ-1:0]  drv_v;
    logic [NREQ-1:0]  drv_we;
    logic [ADDRW-1:0] drv_a [NREQ];
    logic [DATAW-1:0] drv_d [NREQ];

    always_comb begin
        bus.req_valid = drv_v;
        bus.req_we    = drv_we;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*ADDRW +: ADDRW]  = drv_a[i];
            bus.req_wdata[i*DATAW +: DATAW] = drv_d[i];
        end
    end

    // ---------------- reference model ----------------
    int               m_wr_ptr, m_rd_ptr;
    logic [31:0]      m_stall;
    logic [DATAW-1:0] ref_mem [64];
    logic [DATAW-1:0] exp_q [$];
    int               exp_idx_q [$];

    logic [NREQ-1:0]    exp_ready;
    logic [3:0]         exp_wen, exp_rvld;
    logic [ADDRW-1:0]   exp_wadd [4];
    logic [DATAW-1:0]   exp_wdat [4];
    logic [ADDRW-1:0]   exp_radd [4];
    int                 exp_ridx [4];
    int                 exp_wlast, exp_rlast;
    logic [4*ADDRW-1:0] exp_st_wadd, exp_st_radd;
    logic [4*DATAW-1:0] exp_st_wdat;
    logic [NREQ-1:0]    exp_rsp_v;
    logic [DATAW-1:0]   exp_rsp_d [NREQ];

    int errors = 0;
    int checks = 0;

    // Expected grants for the requests currently driven: write list first, then reads.
    function automatic void model_grants();
        logic [ADDRW-1:0] wq [$];
        logic [ADDRW-1:0] rq [$];
        int  i;
        bit  clash;
        exp_ready = '0; exp_wen = '0; exp_rvld = '0;
        exp_wlast = -1; exp_rlast = -1;
        for (int p = 0; p < 4; p++) begin
            exp_wadd[p] = '0; exp_wdat[p] = '0; exp_radd[p] = '0; exp_ridx[p] = 0;
        end
        for (int k = 0; k < NREQ; k++) begin
            i = (m_wr_ptr + k) % NREQ;
            if (drv_v[i] && drv_we[i] && wq.size() < 4) begin
                clash = 0;
                foreach (wq[j]) if (wq[j] == drv_a[i]) clash = 1;
                if (!clash) begin
                    exp_wen[wq.size()]  = 1'b1;
                    exp_wadd[wq.size()] = drv_a[i];
                    exp_wdat[wq.size()] = drv_d[i];
                    wq.push_back(drv_a[i]);
                    exp_ready[i] = 1'b1;
                    exp_wlast    = i;
                end
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            i = (m_rd_ptr + k) % NREQ;
            if (drv_v[i] && !drv_we[i] && rq.size() < 4) begin
                clash = 0;
                foreach (wq[j]) if (wq[j] == drv_a[i]) clash = 1;
                if (!clash) begin
                    exp_rvld[rq.size()] = 1'b1;
                    exp_radd[rq.size()] = drv_a[i];
                    exp_ridx[rq.size()] = i;
                    rq.push_back(drv_a[i]);
                    exp_ready[i] = 1'b1;
                    exp_rlast    = i;
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            exp_st_wadd[p*ADDRW +: ADDRW] = exp_wadd[p];
            exp_st_radd[p*ADDRW +: ADDRW] = exp_radd[p];
            exp_st_wdat[p*DATAW +: DATAW] = exp_wdat[p];
        end
    endfunction

    // Apply one clock edge to the model: queue read responses, update memory, pointers, stall count.
    function automatic void commit();
        for (int p = 0; p < 4; p++)
            if (exp_rvld[p]) begin
                exp_q.push_back(ref_mem[exp_radd[p]]);
                exp_idx_q.push_back(exp_ridx[p]);
            end
        for (int p = 0; p < 4; p++)
            if (exp_wen[p]) ref_mem[exp_wadd[p]] = exp_wdat[p];
        if (exp_wlast >= 0) m_wr_ptr = (exp_wlast + 1) % NREQ;
        if (exp_rlast >= 0) m_rd_ptr = (exp_rlast + 1) % NREQ;
        if (((drv_v & ~exp_ready) != '0) && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
    endfunction

    function automatic void model_reset();
        m_wr_ptr = 0; m_rd_ptr = 0; m_stall = '0;
        exp_q.delete(); exp_idx_q.delete();
    endfunction

    // ---------------- driver tasks ----------------
    // Move to the middle of the cycle and compute expectations for it.
    task automatic settle();
        int id;
        @(negedge clk);
        model_grants();
        exp_rsp_v = '0;
        for (int i = 0; i < NREQ; i++) exp_rsp_d[i] = '0;
        while (exp_q.size() > 0) begin
            id = exp_idx_q.pop_front();
            exp_rsp_v[id] = 1'b1;
            exp_rsp_d[id] = exp_q.pop_front();
        end
    endtask

    // Clock edge: commit model, then granted requesters drop their request.
    task automatic advance();
        logic [NREQ-1:0] granted;
        @(posedge clk);
        model_grants();
        granted = exp_ready;
        commit();
        #1;
        drv_v = drv_v & ~granted;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drv_v = '0; drv_v[0] = 1'b1; drv_we[0] = 1'b1; drv_a[0] = 6'd1; drv_d[0] = 64'h1234;
        @(negedge clk);
        checks++; if (st_wrt_en !== 4'b0000) begin errors++; $display("FAIL reset_wrt_en: got %h want 0", st_wrt_en); end
        checks++; if (bus.rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %h want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: nonzero, want 0"); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        checks++; if (dbg_wr_ptr !== 3'd0 || dbg_rd_ptr !== 3'd0) begin errors++; $display("FAIL reset_ptrs: got %0d/%0d want 0/0", dbg_wr_ptr, dbg_rd_ptr); end
        drv_v = '0;
        reset = 1'b1;
        advance();
    endtask

    task automatic test_single_read();
        drv_v[3] = 1'b1; drv_we[3] = 1'b0; drv_a[3] = 6'd5;
        settle();
        checks++; if (bus.req_ready !== 8'h08) begin errors++; $display("FAIL single_ready: got %h want 08", bus.req_ready); end
        checks++; if (st_read_add[0 +: ADDRW] !== 6'd5) begin errors++; $display("FAIL single_port0_addr: got %0d want 5", st_read_add[0 +: ADDRW]); end
        advance();
        settle();
        checks++; if (bus.rsp_valid !== 8'h08) begin errors++; $display("FAIL single_rsp_valid: got %h want 08", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata[3*DATAW +: DATAW] !== 64'hDEAD) begin errors++; $display("FAIL single_rsp_data: got %h want dead", bus.rsp_rdata[3*DATAW +: DATAW]); end
        advance();
    endtask

    task automatic test_write_oversub();
        for (int i = 0; i < NREQ; i++) begin
            drv_v[i] = 1'b1; drv_we[i] = 1'b1; drv_a[i] = 6'(10 + i); drv_d[i] = {$urandom, $urandom};
        end
        settle();
        checks++; if (bus.req_ready !== 8'h0F) begin errors++; $display("FAIL oversub_c1_ready: got %h want 0f", bus.req_ready); end
        checks++; if (st_wrt_en !== 4'hF || st_wrt_add !== exp_st_wadd || st_data_in !== exp_st_wdat) begin errors++; $display("FAIL oversub_c1_ports: got en %h add %h want en f add %h", st_wrt_en, st_wrt_add, exp_st_wadd); end
        advance();
        checks++; if (dbg_wr_ptr !== 3'd4) begin errors++; $display("FAIL oversub_wr_ptr: got %0d want 4", dbg_wr_ptr); end
        settle();
        checks++; if (bus.req_ready !== 8'hF0) begin errors++; $display("FAIL oversub_c2_ready: got %h want f0", bus.req_ready); end
        checks++; if (st_wrt_add[0 +: ADDRW] !== 6'd14 || st_wrt_add[3*ADDRW +: ADDRW] !== 6'd17) begin errors++; $display("FAIL oversub_c2_addr: got %h", st_wrt_add); end
        advance();
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL oversub_stall: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_ww_conflict();
        drv_v = '0;
        drv_v[1] = 1'b1; drv_we[1] = 1'b1; drv_a[1] = 6'd9; drv_d[1] = 64'h11;
        drv_v[2] = 1'b1; drv_we[2] = 1'b1; drv_a[2] = 6'd9; drv_d[2] = 64'h22;
        settle();
        checks++; if (bus.req_ready !== 8'h02) begin errors++; $display("FAIL ww_c1_ready: got %h want 02", bus.req_ready); end
        advance();
        settle();
        checks++; if (bus.req_ready !== 8'h04) begin errors++; $display("FAIL ww_c2_ready: got %h want 04", bus.req_ready); end
        advance();
        settle();
        checks++; if (stk_mem[9] !== 64'h22) begin errors++; $display("FAIL ww_mem9: got %h want 22", stk_mem[9]); end
        advance();
    endtask

    task automatic test_raw();
        drv_v[0] = 1'b1; drv_we[0] = 1'b1; drv_a[0] = 6'd7; drv_d[0] = 64'hAA;
        drv_v[4] = 1'b1; drv_we[4] = 1'b0; drv_a[4] = 6'd7;
        settle();
        checks++; if (bus.req_ready !== 8'h01) begin errors++; $display("FAIL raw_c1_ready: got %h want 01", bus.req_ready); end
        advance();
        settle();
        checks++; if (bus.req_ready !== 8'h10) begin errors++; $display("FAIL raw_c2_ready: got %h want 10", bus.req_ready); end
        advance();
        settle();
        checks++; if (bus.rsp_valid !== 8'h10 || bus.rsp_rdata[4*DATAW +: DATAW] !== 64'hAA) begin errors++; $display("FAIL raw_rsp: got v %h d %h want v 10 d aa", bus.rsp_valid, bus.rsp_rdata[4*DATAW +: DATAW]); end
        advance();
    endtask

    task automatic test_mixed();
        logic [DATAW-1:0] want;
        for (int i = 0; i < 4; i++) begin
            drv_v[i] = 1'b1; drv_we[i] = 1'b0; drv_a[i] = 6'(20 + i);
            drv_v[i+4] = 1'b1; drv_we[i+4] = 1'b1; drv_a[i+4] = 6'(30 + i); drv_d[i+4] = {$urandom, $urandom};
        end
        settle();
        checks++; if (bus.req_ready !== 8'hFF) begin errors++; $display("FAIL mixed_ready: got %h want ff", bus.req_ready); end
        advance();
        settle();
        checks++; if (bus.rsp_valid !== 8'h0F) begin errors++; $display("FAIL mixed_rsp_valid: got %h want 0f", bus.rsp_valid); end
        for (int i = 0; i < 4; i++) begin
            want = 64'hC0DE_0000_0000_0000 + 64'(20 + i);
            checks++; if (bus.rsp_rdata[i*DATAW +: DATAW] !== want) begin errors++; $display("FAIL mixed_rsp_data%0d: got %h want %h", i, bus.rsp_rdata[i*DATAW +: DATAW], want); end
        end
        advance();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!drv_v[i] && $urandom_range(0, 3) != 0) begin
                    drv_v[i]  = 1'b1;
                    drv_we[i] = 1'($urandom_range(0, 1));
                    drv_a[i]  = 6'($urandom_range(0, 7));
                    drv_d[i]  = {$urandom, $urandom};
                end
            end
            settle();
            checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %h want %h", cyc, bus.req_ready, exp_ready); end
            checks++; if (st_wrt_en !== exp_wen || st_wrt_add !== exp_st_wadd || st_data_in !== exp_st_wdat) begin errors++; $display("FAIL rnd_wports c%0d: got en %h add %h want en %h add %h", cyc, st_wrt_en, st_wrt_add, exp_wen, exp_st_wadd); end
            checks++; if (st_read_add !== exp_st_radd) begin errors++; $display("FAIL rnd_rports c%0d: got %h want %h", cyc, st_read_add, exp_st_radd); end
            checks++; if (bus.rsp_valid !== exp_rsp_v) begin errors++; $display("FAIL rnd_rsp_valid c%0d: got %h want %h", cyc, bus.rsp_valid, exp_rsp_v); end
            for (int i = 0; i < NREQ; i++) begin
                checks++; if (bus.rsp_rdata[i*DATAW +: DATAW] !== exp_rsp_d[i]) begin errors++; $display("FAIL rnd_rsp_data c%0d r%0d: got %h want %h", cyc, i, bus.rsp_rdata[i*DATAW +: DATAW], exp_rsp_d[i]); end
            end
            checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %0d want %0d", cyc, stall_cnt, m_stall); end
            checks++; if (int'(dbg_wr_ptr) != m_wr_ptr || int'(dbg_rd_ptr) != m_rd_ptr) begin errors++; $display("FAIL rnd_ptrs c%0d: got %0d/%0d want %0d/%0d", cyc, dbg_wr_ptr, dbg_rd_ptr, m_wr_ptr, m_rd_ptr); end
            advance();
        end
        // Let every pending request drain before the next scenario.
        for (int n = 0; n < 8 && drv_v != '0; n++) begin
            settle();
            advance();
        end
        checks++; if (drv_v !== '0) begin errors++; $display("FAIL rnd_drain: pending %h want 0", drv_v); end
        settle();
        checks++; if (bus.rsp_valid !== exp_rsp_v) begin errors++; $display("FAIL rnd_final_rsp: got %h want %h", bus.rsp_valid, exp_rsp_v); end
        advance();
    endtask

    task automatic test_reset_mid_read();
        drv_v = '0;
        drv_v[6] = 1'b1; drv_we[6] = 1'b0; drv_a[6] = 6'd3;
        drv_v[1] = 1'b1; drv_we[1] = 1'b1; drv_a[1] = 6'd40; drv_d[1] = 64'hBAD;
        settle();
        checks++; if (bus.req_ready[6] !== 1'b1) begin errors++; $display("FAIL midrst_grant: got %b want 1", bus.req_ready[6]); end
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (st_wrt_en !== 4'b0000) begin errors++; $display("FAIL midrst_wrt_en: got %h want 0", st_wrt_en); end
        checks++; if (dbg_wr_ptr !== 3'd0 || dbg_rd_ptr !== 3'd0) begin errors++; $display("FAIL midrst_ptrs: got %0d/%0d want 0/0", dbg_wr_ptr, dbg_rd_ptr); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL midrst_stall: got %0d want 0", stall_cnt); end
        @(posedge clk);
        #1;
        checks++; if (bus.rsp_valid !== '0) begin errors++; $display("FAIL midrst_rsp_in_reset: got %h want 0", bus.rsp_valid); end
        drv_v = '0;
        @(negedge clk);
        reset = 1'b1;
        advance();
        settle();
        checks++; if (bus.rsp_valid !== '0 || bus.rsp_rdata !== '0) begin errors++; $display("FAIL midrst_rsp_after: got %h want 0", bus.rsp_valid); end
        checks++; if (stk_mem[40] !== ref_mem[40]) begin errors++; $display("FAIL midrst_mem40: got %h want %h", stk_mem[40], ref_mem[40]); end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        drv_v = '0; drv_we = '0;
        for (int i = 0; i < NREQ; i++) begin drv_a[i] = '0; drv_d[i] = '0; end
        st_data_out = '0;
        for (int a = 0; a < 64; a++) begin
            ref_mem[a] = 64'hC0DE_0000_0000_0000 + 64'(a);
            stk_mem[a] = ref_mem[a];
        end
        ref_mem[5] = 64'hDEAD;
        stk_mem[5] = 64'hDEAD;
        model_reset();

        test_reset();
        test_single_read();
        test_write_oversub();
        test_ww_conflict();
        test_raw();
        test_mixed();
        test_random();
        test_reset_mid_read();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Time limit: the sequence is a few thousand cycles at most.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/stack_port_sched.md
Name: stack_port_sched

Overview:
- Shares the 4-read / 4-write-port stack memory among NREQ requesters (Sephirot lanes plus helper engines).
- Each cycle it grants up to 4 reads and up to 4 writes, round-robin, with a valid/ready handshake.
- It resolves same-cycle address hazards and returns read data one cycle after grant.
- It sits directly in front of the stack instance and drives all of its port inputs.

Parameters:
- NREQ, 8, number of requesters (2..16).
- ADDRW, 6, stack address width (log2 of 64 entries).
- DATAW, 64, stack word width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  request present, one bit per requester.
- req_we  input  NREQ  1 = write, 0 = read.
- req_addr  input  NREQ*ADDRW  packed addresses; requester i at [i*ADDRW +: ADDRW].
- req_wdata  input  NREQ*DATAW  packed write data.
- req_ready  output  NREQ  grant, combinational, same cycle.
- rsp_valid  output  NREQ  read data valid, registered.
- rsp_rdata  output  NREQ*DATAW  read data, packed.
- st_read_add  output  4*ADDRW  stack read addresses, ports 0..3.
- st_data_out  input  4*DATAW  stack read data (1-cycle latency).
- st_wrt_add  output  4*ADDRW  stack write addresses.
- st_wrt_en  output  4  stack write enables.
- st_data_in  output  4*DATAW  stack write data.
- stall_cnt  output  32  saturating count of cycles with at least one valid, ungranted request.

Behaviour:
- Handshake: a request transfers when req_valid[i] & req_ready[i]. The requester holds valid/we/addr/wdata stable until granted. req_ready never depends on req_ready.
- Write arbitration, pointer wr_ptr:
  - Scan requesters wr_ptr, wr_ptr+1, ... mod NREQ for valid writes.
  - Each granted write takes the next free write port in scan order (0,1,2,3). Stop after 4 grants.
  - A write whose addr equals an already-granted write this cycle is not granted, uses no port, and the scan continues.
- Read arbitration, pointer rd_ptr:
  - Same scan over valid reads, assigning ports 0..3.
  - A read whose addr equals any granted write this cycle is not granted (RAW deferral: it reads the new value next cycle).
  - Reads to equal addresses may all be granted.
- Pointer update at clock edge: each pointer moves to (last granted index + 1) mod NREQ. It is unchanged if that class granted nothing.
- Stack drive, combinational from grants:
  - Unused read ports: address 0.
  - Unused write ports: en 0, address 0, data 0.
  - st_wrt_en is forced to 0 while reset is low.
- Read return:
  - Per-port grant map is registered: 4 x (valid, requester index).
  - Next cycle: rsp_valid[idx] = 1 and rsp_rdata[idx] = st_data_out[port] for each registered valid entry.
  - All other rsp_valid bits are 0 and their rsp_rdata is 0.
  - Latency is exactly 1 cycle after grant. Back-to-back reads from one requester give back-to-back responses.
- stall_cnt increments when (req_valid & ~req_ready) != 0 and saturates at 0xFFFFFFFF.
- Reset (async, low), mid-operation included:
  - wr_ptr = rd_ptr = 0.
  - Grant map cleared, so rsp_valid = 0 and rsp_rdata = 0.
  - stall_cnt = 0.
  - A read granted in the cycle reset asserts never produces a response.
- A requester may issue one operation per cycle. Read and write from the same requester are impossible by construction.

Test Plan:
- Single read: after reset, requester 3 reads addr 5 holding 0xDEAD -> req_ready[3]=1 same cycle, st_read_add port0=5; next cycle rsp_valid=0x08, rsp_rdata[3]=0xDEAD.
- Write oversubscription: NREQ=8, all 8 write distinct addrs -> cycle 1 grants 0-3 on ports 0-3, wr_ptr=4; cycle 2 grants 4-7; stall_cnt=1.
- Write-write conflict: req 1 and req 2 both write addr 9 (data 0x11 / 0x22), wr_ptr=0 -> only req 1 granted; req 2 granted next cycle; final mem[9]=0x22.
- RAW deferral: req 0 writes addr 7 = 0xAA, req 4 reads addr 7 same cycle -> read not granted; granted next cycle; response 0xAA.
- Mixed load: 4 reads + 4 writes on distinct addrs -> all 8 granted in one cycle; 4 responses the following cycle, routed to the correct requesters.
- Reset mid-read: reset pulled low in the grant cycle of a read -> no rsp_valid afterwards; pointers 0; stall_cnt 0; st_wrt_en 0 while low.
